// File: rtl/pc_pkg.sv
// Shared opcode encodings for the fetch-stage program counter.
package pc_pkg;
  localparam int OP_W = 3;
  localparam logic [OP_W-1:0] OP_NEXT = 3'd0;
  localparam logic [OP_W-1:0] OP_JABS = 3'd1;
  localparam logic [OP_W-1:0] OP_JREL = 3'd2;
  localparam logic [OP_W-1:0] OP_CALL = 3'd3;
  localparam logic [OP_W-1:0] OP_RET  = 3'd4;
  localparam logic [OP_W-1:0] OP_TRAP = 3'd5;
endpackage

// File: rtl/ret_stack.sv
// Circular return-address LIFO; a push when full overwrites the oldest entry.
module ret_stack #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 8,
  localparam int DW = $clog2(STACK_DEPTH + 1),
  localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [PW-1:0]    ptr_q, ptr_inc, ptr_dec;
  logic [DW-1:0]    depth_q;

  // Explicit wrap so non-power-of-two depths stay circular.
  assign ptr_inc = (ptr_q == PW'(STACK_DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign ptr_dec = (ptr_q == '0) ? PW'(STACK_DEPTH - 1) : ptr_q - 1'b1;

  assign full  = (depth_q == DW'(STACK_DEPTH));
  assign empty = (depth_q == '0);
  assign depth = depth_q;
  assign top   = empty ? '0 : mem_q[ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= PW'(STACK_DEPTH - 1);
      depth_q <= '0;
    end else if (push) begin
      ptr_q <= ptr_inc;
      if (!full) depth_q <= depth_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_q   <= ptr_dec;
      depth_q <= depth_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[ptr_inc] <= data;
  end
endmodule

// File: rtl/pc_stack.sv
// Fetch-stage program counter with jumps, trap entry and a return-address stack.
module pc_stack
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               STEP         = 2,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(16'h0010),
  parameter int               STACK_DEPTH  = 8
) (
  input  logic                               I_clk,
  input  logic                               I_reset,
  input  logic                               I_enable,
  input  logic [OP_W-1:0]                    I_op,
  input  logic [WIDTH-1:0]                   I_target,
  output logic [WIDTH-1:0]                   O_out,
  output logic [WIDTH-1:0]                   O_ret_addr,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   O_depth,
  output logic                               O_overflow,
  output logic                               O_underflow
);
  logic [WIDTH-1:0] pc_q, pc_d, pc_seq, push_data, top;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push, pop, full, empty;

  assign pc_seq = pc_q + WIDTH'(STEP);

  always_comb begin
    pc_d      = pc_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = pc_seq;
    if (I_enable) begin
      case (I_op)
        OP_JABS: pc_d = I_target;
        OP_JREL: pc_d = pc_q + I_target;
        OP_CALL: begin
          push = 1'b1;
          pc_d = I_target;
        end
        OP_RET: begin
          // Popping an empty stack degrades to a sequential step.
          if (empty) begin
            unf_d = 1'b1;
            pc_d  = pc_seq;
          end else begin
            pop  = 1'b1;
            pc_d = top;
          end
        end
        OP_TRAP: begin
          push      = 1'b1;
          push_data = pc_q;
          pc_d      = TRAP_VECTOR;
        end
        default: pc_d = pc_seq;
      endcase
      if (push && full) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      pc_q  <= RESET_VECTOR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  ret_stack #(.WIDTH(WIDTH), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk   (I_clk),
    .reset (I_reset),
    .push  (push),
    .pop   (pop),
    .data  (push_data),
    .top   (top),
    .depth (O_depth),
    .full  (full),
    .empty (empty)
  );

  assign O_out       = pc_q;
  assign O_ret_addr  = top;
  assign O_overflow  = ovf_q;
  assign O_underflow = unf_q;
endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack: directed scenarios plus random ops against a queue-based model.
module tb_pc_stack;
  logic        I_clk = 1'b0;
  logic        I_reset = 1'b0, I_enable = 1'b0;
  logic [2:0]  I_op = 3'd0;
  logic [15:0] I_target = 16'h0;
  logic [15:0] O_out, O_ret_addr;
  logic [3:0]  O_depth;
  logic        O_overflow, O_underflow;

  int n_pass = 0, n_total = 0;

  logic [15:0] m_pc = 16'h0;
  logic [15:0] m_stk [$];
  logic        m_ovf = 1'b0, m_unf = 1'b0;

  pc_stack dut (
    .I_clk(I_clk), .I_reset(I_reset), .I_enable(I_enable), .I_op(I_op),
    .I_target(I_target), .O_out(O_out), .O_ret_addr(O_ret_addr),
    .O_depth(O_depth), .O_overflow(O_overflow), .O_underflow(O_underflow)
  );

  always #5 I_clk = ~I_clk;

  function automatic logic [15:0] m_ret();
    return (m_stk.size() == 0) ? 16'h0 : m_stk[$];
  endfunction

  task automatic m_push(input logic [15:0] v);
    if (m_stk.size() == 8) begin
      void'(m_stk.pop_front());
      m_ovf = 1'b1;
    end
    m_stk.push_back(v);
  endtask

  // One clock: drive inputs, advance the reference model, settle past the edge.
  task automatic drive(input logic rst, input logic en, input logic [2:0] op, input logic [15:0] tgt);
    I_reset = rst; I_enable = en; I_op = op; I_target = tgt;
    @(posedge I_clk);
    if (rst) begin
      m_pc = 16'h0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (en) begin
      case (op)
        3'd1: m_pc = tgt;
        3'd2: m_pc = m_pc + tgt;
        3'd3: begin m_push(m_pc + 16'd2); m_pc = tgt; end
        3'd4: if (m_stk.size() == 0) begin m_unf = 1'b1; m_pc = m_pc + 16'd2; end
              else m_pc = m_stk.pop_back();
        3'd5: begin m_push(m_pc); m_pc = 16'h0010; end
        default: m_pc = m_pc + 16'd2;
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 3'd0, 16'h0);
    drive(1, 1, 3'd3, 16'h1234);
    n_total++; if (O_out !== 16'h0) $display("FAIL reset_out got=%h exp=0000", O_out); else n_pass++;
    n_total++; if (O_depth !== 4'd0) $display("FAIL reset_depth got=%0d exp=0", O_depth); else n_pass++;
    n_total++; if (O_ret_addr !== 16'h0) $display("FAIL reset_ret got=%h exp=0000", O_ret_addr); else n_pass++;
    n_total++; if ({O_overflow, O_underflow} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {O_overflow, O_underflow}); else n_pass++;
  endtask

  task automatic test_next_hold();
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1, 3'd0, 16'hFFFF);
      n_total++; if (O_out !== 16'(2 * i)) $display("FAIL next_%0d got=%h exp=%h", i, O_out, 16'(2 * i)); else n_pass++;
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 3'd1, 16'hABCD);
      n_total++; if (O_out !== 16'h0006) $display("FAIL hold_%0d got=%h exp=0006", i, O_out); else n_pass++;
    end
  endtask

  task automatic test_call_ret();
    drive(0, 1, 3'd1, 16'h0100);
    drive(0, 1, 3'd3, 16'h0400);
    n_total++; if (O_out !== 16'h0400) $display("FAIL call_out got=%h exp=0400", O_out); else n_pass++;
    n_total++; if (O_ret_addr !== 16'h0102) $display("FAIL call_ret got=%h exp=0102", O_ret_addr); else n_pass++;
    n_total++; if (O_depth !== 4'd1) $display("FAIL call_depth got=%0d exp=1", O_depth); else n_pass++;
    drive(0, 1, 3'd4, 16'h0);
    n_total++; if (O_out !== 16'h0102) $display("FAIL ret_out got=%h exp=0102", O_out); else n_pass++;
    n_total++; if (O_depth !== 4'd0 || O_ret_addr !== 16'h0) $display("FAIL ret_empty depth=%0d ret=%h exp 0/0000", O_depth, O_ret_addr); else n_pass++;
  endtask

  task automatic test_jrel_wrap();
    drive(0, 1, 3'd1, 16'h0010);
    drive(0, 1, 3'd2, 16'hFFF8);
    n_total++; if (O_out !== 16'h0008) $display("FAIL jrel_neg got=%h exp=0008", O_out); else n_pass++;
    drive(0, 1, 3'd1, 16'hFFFE);
    drive(0, 1, 3'd0, 16'h0);
    n_total++; if (O_out !== 16'h0000) $display("FAIL next_wrap got=%h exp=0000", O_out); else n_pass++;
  endtask

  task automatic test_overflow_underflow();
    logic [15:0] pushed [9];
    drive(1, 0, 3'd0, 16'h0);
    drive(0, 1, 3'd1, 16'h1000);
    for (int i = 0; i < 9; i++) begin
      pushed[i] = (i == 0) ? 16'h1002 : 16'(16'h2000 + (i - 1) * 16 + 2);
      drive(0, 1, 3'd3, 16'(16'h2000 + i * 16));
    end
    n_total++; if (O_depth !== 4'd8 || O_overflow !== 1'b1) $display("FAIL overflow depth=%0d ovf=%b exp 8/1", O_depth, O_overflow); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 3'd4, 16'h0);
      n_total++; if (O_out !== pushed[8 - k]) $display("FAIL ret_order_%0d got=%h exp=%h", k, O_out, pushed[8 - k]); else n_pass++;
    end
    drive(0, 1, 3'd4, 16'h0);
    n_total++; if (O_underflow !== 1'b1 || O_out !== 16'h2004 || O_depth !== 4'd0)
      $display("FAIL underflow unf=%b out=%h depth=%0d exp 1/2004/0", O_underflow, O_out, O_depth); else n_pass++;
  endtask

  task automatic test_trap();
    drive(1, 0, 3'd0, 16'h0);
    drive(0, 1, 3'd1, 16'h0234);
    drive(0, 1, 3'd5, 16'h7777);
    n_total++; if (O_out !== 16'h0010 || O_ret_addr !== 16'h0234 || O_depth !== 4'd1)
      $display("FAIL trap out=%h ret=%h depth=%0d exp 0010/0234/1", O_out, O_ret_addr, O_depth); else n_pass++;
    drive(0, 1, 3'd6, 16'h5555);
    n_total++; if (O_out !== 16'h0012 || {O_overflow, O_underflow} !== 2'b00 || O_depth !== 4'd1)
      $display("FAIL op6 out=%h flags=%b depth=%0d exp 0012/00/1", O_out, {O_overflow, O_underflow}, O_depth); else n_pass++;
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 3'd0, 16'h0);
    drive(0, 1, 3'd4, 16'h0);
    for (int i = 0; i < 10; i++) drive(0, 1, 3'd3, 16'h0300);
    for (int i = 0; i < 5; i++) drive(0, 1, 3'd4, 16'h0);
    n_total++; if (O_depth !== 4'd3 || {O_overflow, O_underflow} !== 2'b11)
      $display("FAIL premid depth=%0d flags=%b exp 3/11", O_depth, {O_overflow, O_underflow}); else n_pass++;
    drive(1, 1, 3'd3, 16'h0500);
    n_total++; if (O_out !== 16'h0 || O_depth !== 4'd0 || {O_overflow, O_underflow} !== 2'b00 || O_ret_addr !== 16'h0)
      $display("FAIL reset_mid out=%h depth=%0d flags=%b ret=%h exp 0000/0/00/0000", O_out, O_depth, {O_overflow, O_underflow}, O_ret_addr); else n_pass++;
    drive(0, 0, 3'd0, 16'h0);
    n_total++; if (O_depth !== 4'd0) $display("FAIL reset_nopush depth=%0d exp=0", O_depth); else n_pass++;
  endtask

  task automatic test_random();
    drive(1, 0, 3'd0, 16'h0);
    for (int i = 0; i < 600; i++) begin
      logic rst, en;
      logic [2:0] op;
      logic [15:0] tgt;
      rst = ($urandom_range(0, 99) < 2);
      en  = ($urandom_range(0, 9) != 0);
      op  = 3'($urandom_range(0, 7));
      tgt = 16'($urandom);
      drive(rst, en, op, tgt);
      n_total++;
      if (O_out !== m_pc || O_ret_addr !== m_ret() || O_depth !== 4'(m_stk.size()) ||
          O_overflow !== m_ovf || O_underflow !== m_unf)
        $display("FAIL rand_%0d out=%h/%h ret=%h/%h depth=%0d/%0d ovf=%b/%b unf=%b/%b (got/exp)",
                 i, O_out, m_pc, O_ret_addr, m_ret(), O_depth, m_stk.size(), O_overflow, m_ovf, O_underflow, m_unf);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_next_hold();
    test_call_ret();
    test_jrel_wrap();
    test_overflow_underflow();
    test_trap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter for the CPU fetch stage. Generalises the fixed 16-bit PC with its +2 increment.
- Adds configurable width, step and reset vector.
- Adds relative and absolute jumps and a trap entry.
- Adds a hardware return-address stack for CALL/RET, with overflow and underflow reporting.

Parameters:
- WIDTH, 16, PC and address width in bits.
- STEP, 2, sequential increment in bytes.
- RESET_VECTOR, 0, PC value after reset.
- TRAP_VECTOR, 16'h0010, PC value loaded by the TRAP op; truncated to WIDTH.
- STACK_DEPTH, 8, number of return-stack entries; must be at least 2.

Ports:
- I_clk, input, 1, clock; all state updates on the rising edge.
- I_reset, input, 1, synchronous active-high reset; overrides I_enable.
- I_enable, input, 1, advance/update strobe; when 0 all state is held.
- I_op, input, 3, operation select (see Behaviour).
- I_target, input, WIDTH, absolute target (JABS/CALL) or two's-complement offset (JREL).
- O_out, output, WIDTH, current PC (registered).
- O_ret_addr, output, WIDTH, top-of-stack value (combinational peek); 0 when the stack is empty.
- O_depth, output, $clog2(STACK_DEPTH+1), number of valid stack entries.
- O_overflow, output, 1, sticky flag: a CALL/TRAP was issued while the stack was full.
- O_underflow, output, 1, sticky flag: a RET was issued while the stack was empty.

Behaviour:
- Interface: one clock, I_clk. Reset I_reset is synchronous and active-high.
- Reset (sampled on a rising edge, regardless of I_enable):
  - O_out = RESET_VECTOR, O_depth = 0, O_overflow = 0, O_underflow = 0.
  - Stack contents are don't-care; O_ret_addr reads 0.
- Reset mid-operation: same result. Any op presented in the reset cycle is discarded.
- I_enable = 0: O_out, the stack, O_depth and both flags are held; I_op is ignored.
- I_enable = 1: the op takes effect on the edge and O_out shows the new PC one cycle later (latency 1). Ops:
  - 0 NEXT: O_out <= O_out + STEP.
  - 1 JABS: O_out <= I_target.
  - 2 JREL: O_out <= O_out + I_target, with I_target taken as signed.
  - 3 CALL: push O_out + STEP; O_out <= I_target.
  - 4 RET: pop; O_out <= popped value.
  - 5 TRAP: push O_out (the faulting PC, not PC+STEP); O_out <= TRAP_VECTOR.
  - 6, 7 reserved: behave exactly as NEXT; no flag is set.
- Arithmetic is modulo 2^WIDTH with silent wrap: all-ones + STEP wraps to STEP-1, and negative JREL offsets wrap below 0.
- Stack organisation:
  - Circular LIFO; the top pointer advances on push and retreats on pop.
  - O_depth saturates at STACK_DEPTH.
- Push when full (O_depth == STACK_DEPTH):
  - The new value overwrites the oldest entry and becomes the top.
  - O_depth stays at STACK_DEPTH and O_overflow is set.
  - The jump still happens.
- Pop when empty:
  - O_underflow is set, the stack is unchanged, and O_out <= O_out + STEP (treated as NEXT).
- O_ret_addr always reflects the current top after the edge. A CALL followed immediately by a RET returns to the CALL address + STEP.
- Flags are sticky and are cleared only by I_reset.
- No simultaneous push and pop is possible: exactly one op per enabled cycle.

Decomposition:
- Shared package pc_pkg holds:
  - opcode localparams OP_NEXT, OP_JABS, OP_JREL, OP_CALL, OP_RET, OP_TRAP;
  - opcode width constant OP_W = 3.
- Sub-module ret_stack (parameters WIDTH, STACK_DEPTH):
  - inputs: clk, reset, push, pop, data;
  - outputs: top, depth, full, empty;
  - circular overwrite-on-full behaviour.
- pc_stack contains the next-PC mux, the adder and the flag registers.

Test Plan:
- Reset then 3x NEXT (enable=1) -> O_out 0, 2, 4, 6. Enable=0 for 2 cycles -> O_out stays 6.
- At O_out=0x0100, CALL target=0x0400 -> O_out=0x0400, O_ret_addr=0x0102, O_depth=1. Then RET -> O_out=0x0102, O_depth=0, O_ret_addr=0.
- JREL with O_out=0x0010, I_target=0xFFF8 (-8) -> 0x0008. O_out=0xFFFE then NEXT -> 0x0000 (wrap).
- 9 nested CALLs (depth 8) -> O_overflow=1, O_depth=8. Then 8 RETs return the 8 newest addresses in reverse order; the 9th RET -> O_underflow=1 and PC+2.
- TRAP at O_out=0x0234 -> O_out=0x0010, O_ret_addr=0x0234. Opcode 6 at 0x0010 -> 0x0012, flags unchanged.
- I_reset asserted together with CALL while depth=3 and flags set -> next cycle O_out=RESET_VECTOR, O_depth=0, both flags 0, no push.
